// File: rtl/topo2a_ad_proj_div_pkg.sv
// ============================================================================
// Module   : topo2a_ad_proj_div_pkg
// Brief    : Widths, quotient limits and FSM state type for the AD projection
//            sequential signed-by-unsigned divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package topo2a_ad_proj_div_pkg;

    localparam int DIVIDEND_W = 23;
    localparam int DIVISOR_W  = 6;
    localparam int QUOT_W     = 19;
    localparam int REM_W      = DIVISOR_W + 1;
    localparam int CNT_W      = 5;

    localparam logic [CNT_W-1:0]         CNT_INIT  = CNT_W'(DIVIDEND_W - 1);
    localparam logic signed [QUOT_W-1:0] QUOT_MAX  = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic signed [QUOT_W-1:0] QUOT_MIN  = {1'b1, {(QUOT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // A wide signed value fits QUOT_W when all bits from QUOT_W-1 upward agree.
    function automatic logic quot_fits(input logic [DIVIDEND_W-1:0] q);
        logic [DIVIDEND_W-QUOT_W:0] top;
        top = q[DIVIDEND_W-1:QUOT_W-1];
        return (&top) | ~(|top);
    endfunction

endpackage

`default_nettype wire

// File: rtl/topo2a_ad_proj_udiv_step.sv
// ============================================================================
// Module   : topo2a_ad_proj_udiv_step
// Brief    : One combinational restoring radix-2 division step on unsigned
//            magnitudes: shift in a dividend bit, subtract divisor if it fits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module topo2a_ad_proj_udiv_step
    import topo2a_ad_proj_div_pkg::*;
(
    input  logic [DIVISOR_W-1:0] rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] shifted;
    logic [DIVISOR_W:0] diff;

    // Partial remainder is always below the divisor, so a non-restored
    // shifted value still fits DIVISOR_W bits.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {1'b0, divisor};
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? diff[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/topo2a_ad_proj_sdiv_23s_6ns_seq.sv
// ============================================================================
// Module   : topo2a_ad_proj_sdiv_23s_6ns_seq
// Brief    : Sequential 23s / 6u divider, one quotient bit per cycle, C
//            truncation semantics, valid/ready on both sides.
//            Macro TOPO2A_DIV_SAT_EN: saturate quotient on overflow (else wrap).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module topo2a_ad_proj_sdiv_23s_6ns_seq
    import topo2a_ad_proj_div_pkg::*;
(
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] din0,
    input  logic [DIVISOR_W-1:0]  din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     quot,
    output logic [REM_W-1:0]      rem,
    output logic                  dz,
    output logic                  ovf
);

    div_state_e            state_q, state_d;
    logic [DIVIDEND_W-1:0] dq_q, dq_d;
    logic [DIVISOR_W-1:0]  div_q, div_d;
    logic [DIVISOR_W-1:0]  prem_q, prem_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  neg_q, neg_d;
    logic [QUOT_W-1:0]     quot_q, quot_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic                  dz_q, dz_d;
    logic                  ovf_q, ovf_d;

    logic [DIVISOR_W-1:0]  step_rem;
    logic                  step_qbit;
    logic [DIVIDEND_W-1:0] q_mag;
    logic [DIVIDEND_W-1:0] q_int;
    logic                  q_fits;
    logic [QUOT_W-1:0]     quot_fin;
    logic [REM_W-1:0]      rem_fin;

    // dq_q starts as the dividend magnitude and fills with quotient bits
    // from the LSB as the dividend bits are consumed from the MSB.
    topo2a_ad_proj_udiv_step u_step (
        .rem_in  (prem_q),
        .bit_in  (dq_q[DIVIDEND_W-1]),
        .divisor (div_q),
        .rem_out (step_rem),
        .q_bit   (step_qbit)
    );

    always_comb begin
        q_mag   = {dq_q[DIVIDEND_W-2:0], step_qbit};
        q_int   = neg_q ? -q_mag : q_mag;
        q_fits  = quot_fits(q_int);
        rem_fin = neg_q ? -{1'b0, step_rem} : {1'b0, step_rem};
`ifdef TOPO2A_DIV_SAT_EN
        quot_fin = q_fits ? q_int[QUOT_W-1:0]
                          : (q_int[DIVIDEND_W-1] ? QUOT_MIN : QUOT_MAX);
`else
        quot_fin = q_int[QUOT_W-1:0];
`endif
    end

    always_comb begin
        state_d = state_q;
        dq_d    = dq_q;
        div_d   = div_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    neg_d  = din0[DIVIDEND_W-1];
                    dq_d   = din0[DIVIDEND_W-1] ? -din0 : din0;
                    div_d  = din1;
                    prem_d = '0;
                    cnt_d  = CNT_INIT;
                    if (din1 == '0) begin
                        dz_d    = 1'b1;
                        ovf_d   = 1'b0;
                        rem_d   = '0;
                        quot_d  = din0[DIVIDEND_W-1] ? QUOT_MIN : QUOT_MAX;
                        state_d = ST_DONE;
                    end else begin
                        dz_d    = 1'b0;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                dq_d   = q_mag;
                prem_d = step_rem;
                if (cnt_q == '0) begin
                    quot_d  = quot_fin;
                    rem_d   = rem_fin;
                    ovf_d   = ~q_fits;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ST_IDLE;
            dq_q    <= '0;
            div_q   <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dq_q    <= dq_d;
            div_q   <= div_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign quot      = quot_q;
    assign rem       = rem_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;

endmodule

`default_nettype wire
